// File: rtl/pend_enc64to6_pkg.sv
// Shared constants and helpers for the 64-to-6 pending-request encoder.
// The clear-mask helper turns a served index back into its request bit.
package pend_enc64to6_pkg;

    localparam int IDX_W = 6;
    localparam int N_REQ = 64;
    localparam int GRP_W = 8;
    localparam int N_GRP = 8;

    function automatic logic [N_REQ-1:0] onehot64(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/pend_enc64to6_pri8to3.sv
// 8-to-3 lowest-index priority encoder, combinational.
// idx_o is 0 when no input bit is set; any_o tells the cases apart.
module pend_enc64to6_pri8to3 (
    input  logic [7:0] in_i,
    output logic [2:0] idx_o,
    output logic       any_o
);

    always_comb begin
        idx_o = 3'd0;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (in_i[i]) idx_o = 3'(i);
        end
    end

    assign any_o = |in_i;

endmodule

// File: rtl/pend_enc64to6.sv
// Sequential 64-to-6 priority encoder: captures request pulses into a pending
// register and presents the lowest pending index over a Valid/Ack handshake.
module pend_enc64to6
    import pend_enc64to6_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             En,
    input  logic [N_REQ-1:0] w,
    input  logic             Ack,
    input  logic             ClrOvf,
    output logic [IDX_W-1:0] y,
    output logic             Valid,
    output logic             Ovf,
    output logic             Busy
);

    logic [N_REQ-1:0] p_q, p_d;
    logic [IDX_W-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [N_REQ-1:0] set_v;
    logic [N_REQ-1:0] clr_v;

    logic [2:0]       bit_idx [N_GRP];
    logic [N_GRP-1:0] grp_any;
    logic [2:0]       grp_idx;
    logic             sel_any;

    always_comb begin
        set_v = w & {N_REQ{En}};
        clr_v = '0;
        if (valid_q && Ack) clr_v = onehot64(y_q);
        // Set is OR-ed in after the clear, so a re-request in its ack cycle survives.
        p_d = (p_q & ~clr_v) | set_v;
    end

    // Encoder tree on P_next: eight byte-group encoders, then one on their Any flags.
    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        pend_enc64to6_pri8to3 u_grp (
            .in_i  (p_d[g*GRP_W +: GRP_W]),
            .idx_o (bit_idx[g]),
            .any_o (grp_any[g])
        );
    end

    pend_enc64to6_pri8to3 u_sel (
        .in_i  (grp_any),
        .idx_o (grp_idx),
        .any_o (sel_any)
    );

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        if (!valid_q || Ack) begin
            valid_d = sel_any;
            y_d     = sel_any ? {grp_idx, bit_idx[grp_idx]} : '0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ClrOvf) ovf_d = 1'b0;
        if (|(set_v & p_q & ~clr_v)) ovf_d = 1'b1;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            p_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y     = y_q;
    assign Valid = valid_q;
    assign Ovf   = ovf_q;
    assign Busy  = |p_q;

endmodule

// File: tb/tb_pend_enc64to6.sv
// Directed bench for pend_enc64to6: hand-computed expectations checked with
// immediate assertions one step after each rising edge.
module tb_pend_enc64to6;

    logic        Clock;
    logic        Resetn;
    logic        En;
    logic [63:0] w;
    logic        Ack;
    logic        ClrOvf;
    logic [5:0]  y;
    logic        Valid;
    logic        Ovf;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    pend_enc64to6 dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .En     (En),
        .w      (w),
        .Ack    (Ack),
        .ClrOvf (ClrOvf),
        .y      (y),
        .Valid  (Valid),
        .Ovf    (Ovf),
        .Busy   (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [5:0] idx,
                           input logic o, input logic b);
        chk({tag, ".Valid"}, 64'(Valid), 64'(v));
        chk({tag, ".y"},     64'(y),     64'(idx));
        chk({tag, ".Ovf"},   64'(Ovf),   64'(o));
        chk({tag, ".Busy"},  64'(Busy),  64'(b));
    endtask

    initial begin
        Resetn = 1'b0;
        En     = 1'b0;
        w      = '0;
        Ack    = 1'b0;
        ClrOvf = 1'b0;
        #2;
        chk_out("reset", 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        Resetn = 1'b1;
        tick();

        // 1: single request held while unacknowledged
        En = 1'b1;
        w  = 64'h1 << 37;
        tick();
        w = '0;
        chk_out("t1.present", 1'b1, 6'd37, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("t1.hold", 1'b1, 6'd37, 1'b0, 1'b1);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_out("t1.acked", 1'b0, 6'd0, 1'b0, 1'b0);

        // 2: multi-hot pulse drained with Ack held high
        w   = 64'h8000_0000_0001_0100;
        Ack = 1'b1;
        tick();
        w = '0;
        chk_out("t2.y8", 1'b1, 6'd8, 1'b0, 1'b1);
        tick();
        chk_out("t2.y16", 1'b1, 6'd16, 1'b0, 1'b1);
        tick();
        chk_out("t2.y63", 1'b1, 6'd63, 1'b0, 1'b1);
        tick();
        chk_out("t2.empty", 1'b0, 6'd0, 1'b0, 1'b0);
        Ack = 1'b0;

        // 3: no preemption by a lower index
        w = 64'h1 << 20;
        tick();
        w = 64'h1 << 3;
        chk_out("t3.y20", 1'b1, 6'd20, 1'b0, 1'b1);
        tick();
        w = '0;
        chk_out("t3.nopreempt", 1'b1, 6'd20, 1'b0, 1'b1);
        Ack = 1'b1;
        tick();
        chk_out("t3.y3", 1'b1, 6'd3, 1'b0, 1'b1);
        tick();
        Ack = 1'b0;
        chk_out("t3.empty", 1'b0, 6'd0, 1'b0, 1'b0);

        // 4: overflow on re-pulse of a pending bit, clear, re-request in ack cycle
        w = (64'h1 << 2) | (64'h1 << 5);
        tick();
        w = 64'h1 << 5;
        chk_out("t4.y2", 1'b1, 6'd2, 1'b0, 1'b1);
        tick();
        w = '0;
        chk_out("t4.ovf", 1'b1, 6'd2, 1'b1, 1'b1);
        ClrOvf = 1'b1;
        tick();
        ClrOvf = 1'b0;
        chk_out("t4.clrovf", 1'b1, 6'd2, 1'b0, 1'b1);
        w   = 64'h1 << 2;
        Ack = 1'b1;
        tick();
        w = '0;
        chk_out("t4.rereq", 1'b1, 6'd2, 1'b0, 1'b1);
        tick();
        chk_out("t4.y5", 1'b1, 6'd5, 1'b0, 1'b1);
        tick();
        Ack = 1'b0;
        chk_out("t4.once", 1'b0, 6'd0, 1'b0, 1'b0);

        // 5: capture disabled, then all 64 requests in ascending order
        En = 1'b0;
        w  = '1;
        tick();
        chk_out("t5.en0", 1'b0, 6'd0, 1'b0, 1'b0);
        En = 1'b1;
        tick();
        w = '0;
        chk_out("t5.y0", 1'b1, 6'd0, 1'b0, 1'b1);
        Ack = 1'b1;
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("t5.seq", 64'(y), 64'(i));
            chk("t5.seqv", 64'(Valid), 64'd1);
        end
        tick();
        Ack = 1'b0;
        chk_out("t5.empty", 1'b0, 6'd0, 1'b0, 1'b0);

        // 6: asynchronous reset between edges with 10 pending and Ovf set
        w = 64'h3FF;
        tick();
        w = 64'h1 << 9;
        chk_out("t6.y0", 1'b1, 6'd0, 1'b0, 1'b1);
        tick();
        w = '0;
        chk_out("t6.ovf", 1'b1, 6'd0, 1'b1, 1'b1);
        #2;
        Resetn = 1'b0;
        #1;
        chk_out("t6.async", 1'b0, 6'd0, 1'b0, 1'b0);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("t6.idle", 1'b0, 6'd0, 1'b0, 1'b0);
        end
        w = 64'h1 << 7;
        tick();
        w = '0;
        chk_out("t6.newreq", 1'b1, 6'd7, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
